// File: rtl/register_file.sv
// Register file with two combinational read ports and one synchronous write
// port. Index 0 is hard-wired to zero. A synchronous reset clears every entry
// and wins over a write in the same cycle.
module register_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage array. Entry 0 exists only so the index range is uniform; it is
    // never written by a normal write and is masked on every read.
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // A write lands only when enabled and aimed at a non-zero index.
    logic write_hit;
    assign write_hit = wen && (waddr != '0);

    // Storage update: reset clears all entries and overrides any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports are asynchronous and see only the stored value, so a write in
    // progress is not forwarded. Index 0 is forced to zero so it is defined
    // even before the first reset.
    logic [ADDR_WIDTH-1:0] raddr_sel [2];
    logic [DATA_WIDTH-1:0] rdata_sel [2];

    assign raddr_sel[0] = raddr1;
    assign raddr_sel[1] = raddr2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
        // Combinational read mux with the zero-register override.
        always_comb begin
            rdata_sel[gi] = '0;
            if (raddr_sel[gi] != '0) begin
                rdata_sel[gi] = regs[raddr_sel[gi]];
            end
        end
    end

    assign rdata1 = rdata_sel[0];
    assign rdata2 = rdata_sel[1];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a behavioural array model checked on
// every falling edge, plus directed vectors with literal expectations.
module tb_register_file;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;

    int checks = 0;
    int failures = 0;

    // Behavioural model: plain array of expected contents.
    logic [DW-1:0] model [DEPTH];
    bit            model_valid = 1'b0;

    register_file #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    // Model update at each rising edge from the applied inputs.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            model_valid = 1'b1;
        end else if (wen && waddr != 0) begin
            model[waddr] = wdata;
        end
    end

    // Continuous compare of both read ports against the model.
    always @(negedge clk) begin
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        exp1 = (raddr1 == 0) ? '0 : model[raddr1];
        exp2 = (raddr2 == 0) ? '0 : model[raddr2];
        if (model_valid || raddr1 == 0) begin
            checks++;
            if (rdata1 !== exp1) begin
                failures++;
                $display("FAIL model_port1 t=%0t raddr1=%0d got=%h exp=%h", $time, raddr1, rdata1, exp1);
            end
        end
        if (model_valid || raddr2 == 0) begin
            checks++;
            if (rdata2 !== exp2) begin
                failures++;
                $display("FAIL model_port2 t=%0t raddr2=%0d got=%h exp=%h", $time, raddr2, rdata2, exp2);
            end
        end
    end

    task automatic check_lit(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, actual, expected);
        end else begin
            $display("ok   %s value=%h", name, actual);
        end
    endtask

    // Apply current inputs at the next rising edge, return just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hard bound on run length.
    initial begin
        #200000;
        $display("FAIL watchdog run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] expv;
        #1;
        // Register 0 is zero even before any reset.
        raddr1 = '0;
        #1;
        check_lit("pre_reset_r0", rdata1, 32'h0);

        // Reset for one edge, then sweep both ports.
        reset = 1'b1;
        wen = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            raddr1 = AW'(i);
            raddr2 = AW'(DEPTH - 1 - i);
            #1;
            check_lit($sformatf("reset_zero_p1_%0d", i), rdata1, 32'h0);
            check_lit($sformatf("reset_zero_p2_%0d", DEPTH - 1 - i), rdata2, 32'h0);
        end
        step();

        // Write and read back.
        wen = 1'b1; waddr = 5'd5; wdata = 32'h0000_0001;
        step();
        wen = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
        #1;
        check_lit("wr_rd_idx5", rdata1, 32'h0000_0001);
        check_lit("wr_rd_idx6", rdata2, 32'h0);

        // Register 0 protection.
        wen = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
        step();
        wen = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check_lit("r0_protect_p1", rdata1, 32'h0);
        check_lit("r0_protect_p2", rdata2, 32'h0);

        // No bypass: both ports on the index being written.
        wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0010;
        step();
        wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0020; raddr1 = 5'd3; raddr2 = 5'd3;
        #1;
        check_lit("no_bypass_before_p1", rdata1, 32'h0000_0010);
        check_lit("no_bypass_before_p2", rdata2, 32'h0000_0010);
        step();
        wen = 1'b0;
        #1;
        check_lit("no_bypass_after_p1", rdata1, 32'h0000_0020);
        check_lit("no_bypass_after_p2", rdata2, 32'h0000_0020);

        // Full-width value stored unmodified.
        wen = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF;
        step();
        wen = 1'b0; raddr1 = 5'd9;
        #1;
        check_lit("full_width_idx9", rdata1, 32'hFFFF_FFFF);

        // Reset priority and no asynchronous effect of reset between edges.
        wen = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        step();
        wen = 1'b0; raddr2 = 5'd7; raddr1 = 5'd5;
        #1;
        check_lit("pre_rst_idx7", rdata2, 32'h1234_5678);
        reset = 1'b1; wen = 1'b1; waddr = 5'd7; wdata = 32'hFFFF_FFFF;
        #1;
        check_lit("rst_not_async_idx7", rdata2, 32'h1234_5678);
        check_lit("rst_not_async_idx5", rdata1, 32'h0000_0001);
        step();
        reset = 1'b0; wen = 1'b0;
        #1;
        check_lit("rst_priority_idx7", rdata2, 32'h0);
        check_lit("rst_cleared_idx5", rdata1, 32'h0);

        // Full sweep write then read back on both ports.
        for (int i = 1; i < DEPTH; i++) begin
            wen = 1'b1; waddr = AW'(i); wdata = DW'(i) * 32'h0101_0101;
            step();
        end
        wen = 1'b0;
        raddr1 = 5'd0; raddr2 = 5'd31;
        #1;
        check_lit("sweep_idx0", rdata1, 32'h0);
        check_lit("sweep_idx31", rdata2, 32'h1F1F_1F1F);
        for (int i = 0; i < DEPTH; i++) begin
            raddr1 = AW'(i); raddr2 = AW'(i);
            expv = DW'(i) * 32'h0101_0101;
            #1;
            check_lit($sformatf("sweep_p1_%0d", i), rdata1, expv);
            check_lit($sformatf("sweep_p2_%0d", i), rdata2, expv);
        end

        // Idle cycle with random write data/address must change nothing.
        wen = 1'b0;
        waddr = AW'($urandom_range(DEPTH - 1, 1));
        wdata = $urandom;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            raddr1 = AW'(i); raddr2 = AW'(DEPTH - 1 - i);
            #1;
            check_lit($sformatf("idle_p1_%0d", i), rdata1, DW'(i) * 32'h0101_0101);
            check_lit($sformatf("idle_p2_%0d", DEPTH - 1 - i), rdata2, DW'(DEPTH - 1 - i) * 32'h0101_0101);
        end
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
